seq_control_unit: RTL and testbench
===================================

# seq_control_unit

Parametrised decode-stage control unit: combinational decode of the 6-bit opcode into execute, memory, write-back and branch controls, plus a registered micro-sequencer for multi-cycle macro-ops such as SWP. The sequencer generalises the swap operation to `SEQ_STEPS` micro-steps. It asserts `freeze` to hold fetch/decode, adds stall and flush handling, and provides an optional illegal-opcode trap. It sits in ID, feeding the ID/EX register.

## Interface
- `EXEC_W`, default 4: width of `exec_cmd`.
- `SEQ_STEPS`, default 2: micro-steps per sequenced op. Legal range 2..8.
- `SEQ_OPCODE`, default 6'b111111: opcode that starts a sequence.
- `SEQ_CMD_BASE`, default 4'b1100: `exec_cmd` of step 0. Step k issues `SEQ_CMD_BASE + k`, truncated to `EXEC_W`.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instruction opcode from IF/ID.
- `stall`  in  1  hazard stall; inserts a bubble.
- `flush`  in  1  branch-taken flush; aborts the current instruction or sequence.
- `freeze`  out  1  holds PC and IF/ID.
- `seq_sel`  out  SEQ_STEPS  one-hot current micro-step; 0 when not sequencing.
- `exec_cmd`  out  EXEC_W  ALU command.
- `mem_r_en`, `mem_w_en`, `wb_en`, `is_imm`, `single_src`  out  1 each  controls.
- `branch_type`  out  2  branch type: 00 none, 01 BEZ, 10 BNE, 11 JMP.
- `illegal_op`  out  1  sticky illegal-opcode flag.

## Operation
Decode is combinational from `opcode`. Outputs default to 0, then:
- NOP 000000 → cmd 0000.
- ADD 000001 → 0000. SUB 000011 → 0010. AND 000101 → 0100. OR 000110 → 0101.
- NOR 000111 → 0110. XOR 001000 → 0111. SLA/SLL 001001/001010 → 1000. SRA 001011 → 1001. SRL 001100 → 1010.
- Every ALU op above except NOP also sets `wb_en`.
- ADDI 100000 / SUBI 100001 → cmd 0000 / 0010, with `is_imm`, `wb_en`, `single_src`.
- LD 100100 → cmd 0000, `is_imm`, `mem_r_en`, `wb_en`, `single_src`.
- ST 100101 → cmd 0000, `is_imm`, `mem_w_en`.
- BEZ 101000 → `is_imm`, `single_src`, branch 01.
- BNE 101001 → `is_imm`, branch 10.
- JMP 101010 → `is_imm`, `single_src`, branch 11.
- Any other opcode except `SEQ_OPCODE` is illegal and decodes as NOP.

Sequencer states are IDLE and BUSY, with step counter `step` (0..SEQ_STEPS-1).
- **Starting a sequence:** in IDLE with `opcode==SEQ_OPCODE`, the current cycle presents step 0.
- **Each step k:**
  - `exec_cmd=SEQ_CMD_BASE+k`, `wb_en=1`, `seq_sel=1<<k`.
  - `freeze=1` for k<SEQ_STEPS-1; `freeze=0` at the last step.
- **Advancing:** on each edge without `stall`, `step` increments. After the last step, the sequencer returns to IDLE with `step=0`.
- **Opcode ignored in BUSY:** the presented step is always taken from `step`, because IF/ID is frozen during a sequence.
- **Stall:**
  - `wb_en`, `mem_r_en`, `mem_w_en` and `branch_type` are forced to 0.
  - `step` and state hold.
  - `exec_cmd`, `seq_sel` and `freeze` keep their step values, so a stalled non-final step still freezes.
- **Flush:** all outputs are 0 that cycle except `illegal_op`, and the next state is IDLE with `step=0`. Flush has priority over stall and over sequence start.

## Timing
- Decode latency is 0 cycles, combinational from `opcode`.
- A sequence takes exactly SEQ_STEPS cycles plus the number of stalled cycles.
- `freeze` is high for the first SEQ_STEPS-1 presented steps.
- Back-to-back sequences: if `opcode` still equals `SEQ_OPCODE` in the IDLE cycle after a sequence, a new step 0 begins. No idle cycle is inserted.
- Reset:
  - While `rst_n`=0, every output is 0 and the sequencer is forced to IDLE with `step=0`.
  - Asserting reset mid-sequence aborts the sequence immediately.
  - After release, the first edge behaves as IDLE.
- `stall` and `flush` are sampled at the same edge as the opcode decode they affect.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN`:
  - When defined, `illegal_op` is a register. It is set at the edge after an illegal opcode is decoded in IDLE without stall or flush. It is cleared only by `rst_n`.
  - When not defined, `illegal_op` is tied to 0 and no flag register exists.

## Test plan
- ADD, LD, ST, BNE each held for one cycle → cmd 0000/wb_en=1; LD adds `mem_r_en`; ST has `mem_w_en=1` and `wb_en=0`; BNE has `branch_type=10` and `is_imm=1`.
- `SEQ_OPCODE` held with SEQ_STEPS=2 → cycle 0: cmd 1100, sel 01, freeze 1; cycle 1: cmd 1101, sel 10, freeze 0; cycle 2 (opcode NOP): sel 00.
- SEQ_STEPS=4, stall high during step 1 for 2 cycles → step 1 is presented for 3 cycles with wb_en=0 while stalled and freeze=1; the sequence completes in 6 cycles.
- Flush during step 0 → all outputs 0 that cycle; next cycle with NOP opcode, sequencer is IDLE and `seq_sel`=0.
- `rst_n` pulsed low mid-sequence → outputs 0 immediately; after release, `SEQ_OPCODE` restarts at step 0.
- With `CTRL_ILLEGAL_TRAP_EN`, opcode 010101 → decodes as NOP; `illegal_op`=1 from the next edge and stays set until reset. Without the macro, `illegal_op` stays 0.

Source files
------------

// File: rtl/seq_control_unit_if.sv
// Decode-stage control bundle: opcode and hazard inputs in, ID/EX control fields out.
// master drives opcode/stall/flush; slave is the control unit.
interface seq_control_unit_if #(
  parameter int EXEC_W    = 4,
  parameter int SEQ_STEPS = 2
);
  logic [5:0]           opcode;
  logic                 stall;
  logic                 flush;
  logic                 freeze;
  logic [SEQ_STEPS-1:0] seq_sel;
  logic [EXEC_W-1:0]    exec_cmd;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic                 wb_en;
  logic                 is_imm;
  logic                 single_src;
  logic [1:0]           branch_type;
  logic                 illegal_op;

  modport master (
    output opcode, stall, flush,
    input  freeze, seq_sel, exec_cmd, mem_r_en, mem_w_en, wb_en,
           is_imm, single_src, branch_type, illegal_op
  );

  modport slave (
    input  opcode, stall, flush,
    output freeze, seq_sel, exec_cmd, mem_r_en, mem_w_en, wb_en,
           is_imm, single_src, branch_type, illegal_op
  );
endinterface

// File: rtl/seq_control_unit.sv
// ID-stage control unit: combinational opcode decode plus an IDLE/BUSY micro-sequencer
// for multi-step macro-ops. Define CTRL_ILLEGAL_TRAP_EN to enable the sticky illegal-opcode flag.
module seq_control_unit #(
  parameter int         EXEC_W       = 4,
  parameter int         SEQ_STEPS    = 2,
  parameter logic [5:0] SEQ_OPCODE   = 6'b111111,
  parameter logic [3:0] SEQ_CMD_BASE = 4'b1100
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_control_unit_if.slave bus
);

  localparam int STEP_W = (SEQ_STEPS > 2) ? $clog2(SEQ_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_STEPS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [STEP_W-1:0]    step, step_nxt;
  logic [STEP_W-1:0]    cur_step;
  logic                 in_seq;

  logic                 freeze_c;
  logic [SEQ_STEPS-1:0] sel_c;
  logic [EXEC_W-1:0]    cmd_c;
  logic                 mem_r_c, mem_w_c, wb_c, imm_c, single_c;
  logic [1:0]           br_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    freeze_c  = 1'b0;
    sel_c     = '0;
    cmd_c     = '0;
    mem_r_c   = 1'b0;
    mem_w_c   = 1'b0;
    wb_c      = 1'b0;
    imm_c     = 1'b0;
    single_c  = 1'b0;
    br_c      = 2'b00;
    state_nxt = state;
    step_nxt  = step;

    // IF/ID is frozen while BUSY, so the opcode only matters for starting a sequence.
    cur_step = (state == BUSY) ? step : '0;
    in_seq   = (state == BUSY) || (bus.opcode == SEQ_OPCODE);

    if (in_seq) begin
      cmd_c    = EXEC_W'(SEQ_CMD_BASE) + EXEC_W'(cur_step);
      wb_c     = 1'b1;
      sel_c    = SEQ_STEPS'(1) << cur_step;
      freeze_c = (cur_step != LAST_STEP);
    end else begin
      unique case (bus.opcode)
        6'b000001: begin cmd_c = EXEC_W'(4'b0000); wb_c = 1'b1; end
        6'b000011: begin cmd_c = EXEC_W'(4'b0010); wb_c = 1'b1; end
        6'b000101: begin cmd_c = EXEC_W'(4'b0100); wb_c = 1'b1; end
        6'b000110: begin cmd_c = EXEC_W'(4'b0101); wb_c = 1'b1; end
        6'b000111: begin cmd_c = EXEC_W'(4'b0110); wb_c = 1'b1; end
        6'b001000: begin cmd_c = EXEC_W'(4'b0111); wb_c = 1'b1; end
        6'b001001,
        6'b001010: begin cmd_c = EXEC_W'(4'b1000); wb_c = 1'b1; end
        6'b001011: begin cmd_c = EXEC_W'(4'b1001); wb_c = 1'b1; end
        6'b001100: begin cmd_c = EXEC_W'(4'b1010); wb_c = 1'b1; end
        6'b100000: begin cmd_c = EXEC_W'(4'b0000); imm_c = 1'b1; wb_c = 1'b1; single_c = 1'b1; end
        6'b100001: begin cmd_c = EXEC_W'(4'b0010); imm_c = 1'b1; wb_c = 1'b1; single_c = 1'b1; end
        6'b100100: begin
          imm_c = 1'b1; mem_r_c = 1'b1; wb_c = 1'b1; single_c = 1'b1;
        end
        6'b100101: begin imm_c = 1'b1; mem_w_c = 1'b1; end
        6'b101000: begin imm_c = 1'b1; single_c = 1'b1; br_c = 2'b01; end
        6'b101001: begin imm_c = 1'b1; br_c = 2'b10; end
        6'b101010: begin imm_c = 1'b1; single_c = 1'b1; br_c = 2'b11; end
        default:   ;
      endcase
    end

    // A stall turns the slot into a bubble but keeps the step visible, so freeze still holds fetch.
    if (bus.stall) begin
      wb_c    = 1'b0;
      mem_r_c = 1'b0;
      mem_w_c = 1'b0;
      br_c    = 2'b00;
    end

    if (bus.flush) begin
      freeze_c  = 1'b0;
      sel_c     = '0;
      cmd_c     = '0;
      mem_r_c   = 1'b0;
      mem_w_c   = 1'b0;
      wb_c      = 1'b0;
      imm_c     = 1'b0;
      single_c  = 1'b0;
      br_c      = 2'b00;
      state_nxt = IDLE;
      step_nxt  = '0;
    end else if (!bus.stall && in_seq) begin
      if (cur_step == LAST_STEP) begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end else begin
        state_nxt = BUSY;
        step_nxt  = cur_step + STEP_W'(1);
      end
    end
  end

  // Reset blanks the outputs immediately, not just at the next edge.
  assign bus.freeze      = rst_n & freeze_c;
  assign bus.seq_sel     = rst_n ? sel_c : '0;
  assign bus.exec_cmd    = rst_n ? cmd_c : '0;
  assign bus.mem_r_en    = rst_n & mem_r_c;
  assign bus.mem_w_en    = rst_n & mem_w_c;
  assign bus.wb_en       = rst_n & wb_c;
  assign bus.is_imm      = rst_n & imm_c;
  assign bus.single_src  = rst_n & single_c;
  assign bus.branch_type = rst_n ? br_c : 2'b00;

`ifdef CTRL_ILLEGAL_TRAP_EN
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000011, 6'b000101, 6'b000110, 6'b000111,
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100,
      6'b100000, 6'b100001, 6'b100100, 6'b100101,
      6'b101000, 6'b101001, 6'b101010: op_legal = 1'b1;
      default:                         op_legal = 1'b0;
    endcase
  endfunction

  logic illegal_dec;
  logic illegal_q;

  assign illegal_dec = !in_seq && !op_legal(bus.opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_q <= 1'b0;
    else if (illegal_dec && !bus.stall && !bus.flush)
      illegal_q <= 1'b1;
  end

  assign bus.illegal_op = illegal_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: two instances (2-step and 4-step sequences) share stimulus
// and are compared every cycle against a behavioural model, plus directed literal checks.
module tb_seq_control_unit;

  localparam logic [5:0] SEQ = 6'b111111;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct packed {
    logic       ill;
    logic       frz;
    logic [7:0] sel;
    logic [3:0] cmd;
    logic       mr, mw, wb, imm, ss;
    logic [1:0] br;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [5:0] cur_op = '0;
  logic       cur_st = 1'b0;
  logic       cur_fl = 1'b0;

  int   nsteps [2] = '{2, 4};
  int   pos    [2] = '{0, 0};   // micro-steps already completed in the current sequence
  logic ill    [2] = '{1'b0, 1'b0};

  logic [5:0] legal_ops [18] = '{6'h00, 6'h01, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h20, 6'h21, 6'h24, 6'h25,
                                 6'h28, 6'h29, 6'h2A};

  seq_control_unit_if #(.EXEC_W(4), .SEQ_STEPS(2)) bus2 ();
  seq_control_unit_if #(.EXEC_W(4), .SEQ_STEPS(4)) bus4 ();

  seq_control_unit #(.EXEC_W(4), .SEQ_STEPS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  seq_control_unit #(.EXEC_W(4), .SEQ_STEPS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic outs_t model_out(input int n, input int p, input logic [5:0] op,
                                      input logic st, input logic fl, input logic il,
                                      input logic rst_ok);
    outs_t o = '0;
    if (!rst_ok) return o;
    o.ill = il;
    if (fl) return o;
    if (p > 0 || op == SEQ) begin
      o.cmd = 4'(12 + p);
      o.wb  = 1'b1;
      o.sel = 8'(1 << p);
      o.frz = (p < n - 1);
    end else begin
      case (op)
        6'h01: begin o.cmd = 4'd0;  o.wb = 1'b1; end
        6'h03: begin o.cmd = 4'd2;  o.wb = 1'b1; end
        6'h05: begin o.cmd = 4'd4;  o.wb = 1'b1; end
        6'h06: begin o.cmd = 4'd5;  o.wb = 1'b1; end
        6'h07: begin o.cmd = 4'd6;  o.wb = 1'b1; end
        6'h08: begin o.cmd = 4'd7;  o.wb = 1'b1; end
        6'h09, 6'h0A: begin o.cmd = 4'd8; o.wb = 1'b1; end
        6'h0B: begin o.cmd = 4'd9;  o.wb = 1'b1; end
        6'h0C: begin o.cmd = 4'd10; o.wb = 1'b1; end
        6'h20: begin o.imm = 1'b1; o.wb = 1'b1; o.ss = 1'b1; end
        6'h21: begin o.cmd = 4'd2; o.imm = 1'b1; o.wb = 1'b1; o.ss = 1'b1; end
        6'h24: begin o.imm = 1'b1; o.mr = 1'b1; o.wb = 1'b1; o.ss = 1'b1; end
        6'h25: begin o.imm = 1'b1; o.mw = 1'b1; end
        6'h28: begin o.imm = 1'b1; o.ss = 1'b1; o.br = 2'b01; end
        6'h29: begin o.imm = 1'b1; o.br = 2'b10; end
        6'h2A: begin o.imm = 1'b1; o.ss = 1'b1; o.br = 2'b11; end
        default: ;
      endcase
    end
    if (st) begin
      o.wb = 1'b0; o.mr = 1'b0; o.mw = 1'b0; o.br = 2'b00;
    end
    return o;
  endfunction

  function automatic outs_t obs2();
    return {bus2.illegal_op, bus2.freeze, 8'(bus2.seq_sel), bus2.exec_cmd, bus2.mem_r_en,
            bus2.mem_w_en, bus2.wb_en, bus2.is_imm, bus2.single_src, bus2.branch_type};
  endfunction

  function automatic outs_t obs4();
    return {bus4.illegal_op, bus4.freeze, 8'(bus4.seq_sel), bus4.exec_cmd, bus4.mem_r_en,
            bus4.mem_w_en, bus4.wb_en, bus4.is_imm, bus4.single_src, bus4.branch_type};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/dut2"}, 32'(obs2()), 32'(model_out(nsteps[0], pos[0], cur_op, cur_st, cur_fl, ill[0], rst_n)));
    chk({tag, "/dut4"}, 32'(obs4()), 32'(model_out(nsteps[1], pos[1], cur_op, cur_st, cur_fl, ill[1], rst_n)));
  endtask

  // Called just after a rising edge: apply inputs, let decode settle, compare.
  task automatic drive(input logic [5:0] op, input logic st, input logic fl, input string tag);
    cur_op = op; cur_st = st; cur_fl = fl;
    bus2.opcode = op; bus2.stall = st; bus2.flush = fl;
    bus4.opcode = op; bus4.stall = st; bus4.flush = fl;
    #2;
    check_model(tag);
  endtask

  task automatic tick();
    logic in_seq;
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        in_seq = (pos[i] > 0) || (cur_op == SEQ);
        if (TRAP && !in_seq && !is_legal(cur_op) && !cur_st && !cur_fl) ill[i] = 1'b1;
        if (cur_fl) pos[i] = 0;
        else if (!cur_st && in_seq) pos[i] = (pos[i] + 1 == nsteps[i]) ? 0 : pos[i] + 1;
      end
    end
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_model(tag);
    for (int i = 0; i < 2; i++) begin pos[i] = 0; ill[i] = 1'b0; end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] op;
    logic       st, fl;
    int         r;

    // Held in reset: outputs must be zero even with a live opcode.
    drive(6'h01, 1'b0, 1'b0, "reset_hold");
    chk("reset_wb", 32'(bus2.wb_en), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    drive(6'h01, 1'b0, 1'b0, "add");
    chk("add_cmd", 32'(bus2.exec_cmd), 32'h0);
    chk("add_wb", 32'(bus2.wb_en), 32'd1);
    tick();
    drive(6'h24, 1'b0, 1'b0, "ld");
    chk("ld_mem_r", 32'(bus2.mem_r_en), 32'd1);
    tick();
    drive(6'h25, 1'b0, 1'b0, "st");
    chk("st_mem_w", 32'(bus2.mem_w_en), 32'd1);
    chk("st_wb", 32'(bus2.wb_en), 32'd0);
    tick();
    drive(6'h29, 1'b0, 1'b0, "bne");
    chk("bne_br", 32'(bus2.branch_type), 32'b10);
    chk("bne_imm", 32'(bus2.is_imm), 32'd1);
    tick();

    // Two-step sequence, then let the four-step instance drain.
    drive(SEQ, 1'b0, 1'b0, "seq_s0");
    chk("seq2_s0", {bus2.exec_cmd, 2'b0, bus2.seq_sel, 3'b0, bus2.freeze}, {4'hC, 2'b0, 2'b01, 3'b0, 1'b1});
    tick();
    drive(SEQ, 1'b0, 1'b0, "seq_s1");
    chk("seq2_s1", {bus2.exec_cmd, 2'b0, bus2.seq_sel, 3'b0, bus2.freeze}, {4'hD, 2'b0, 2'b10, 3'b0, 1'b0});
    tick();
    drive(6'h00, 1'b0, 1'b0, "seq_after");
    chk("seq2_done_sel", 32'(bus2.seq_sel), 32'd0);
    tick();
    drive(6'h00, 1'b0, 1'b0, "seq4_drain");
    tick();

    // Four-step sequence with step 1 stalled for two cycles: six cycles total.
    drive(SEQ, 1'b0, 1'b0, "stall_s0");
    tick();
    drive(6'h00, 1'b1, 1'b0, "stall_s1a");
    chk("stall_wb", 32'(bus4.wb_en), 32'd0);
    chk("stall_frz_sel", {bus4.freeze, bus4.seq_sel}, {1'b1, 4'b0010});
    tick();
    drive(6'h00, 1'b1, 1'b0, "stall_s1b");
    tick();
    drive(6'h00, 1'b0, 1'b0, "stall_s1c");
    chk("stall_s1_resume", {bus4.wb_en, bus4.seq_sel}, {1'b1, 4'b0010});
    tick();
    drive(6'h00, 1'b0, 1'b0, "stall_s2");
    tick();
    drive(6'h00, 1'b0, 1'b0, "stall_s3");
    chk("stall_s3_last", {bus4.freeze, bus4.exec_cmd}, {1'b0, 4'hF});
    tick();
    drive(6'h00, 1'b0, 1'b0, "stall_done");
    chk("stall_done_sel", 32'(bus4.seq_sel), 32'd0);
    tick();

    // Flush at step 0 aborts the sequence.
    drive(SEQ, 1'b0, 1'b1, "flush_s0");
    chk("flush_zero", {bus2.exec_cmd, bus2.freeze, bus2.wb_en, bus2.seq_sel}, 32'd0);
    tick();
    drive(6'h00, 1'b0, 1'b0, "flush_after");
    chk("flush_idle", {bus2.seq_sel, bus4.seq_sel}, 32'd0);
    tick();

    // Asynchronous reset in the middle of a sequence, then restart.
    drive(SEQ, 1'b0, 1'b0, "rst_s0");
    tick();
    drive(SEQ, 1'b0, 1'b0, "rst_s1");
    pulse_reset("rst_mid");
    chk("rst_mid_zero", {bus4.freeze, bus4.exec_cmd, bus4.seq_sel}, 32'd0);
    drive(SEQ, 1'b0, 1'b0, "rst_restart");
    chk("rst_restart", {bus4.exec_cmd, bus4.seq_sel}, {4'hC, 4'b0001});
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(6'h00, 1'b0, 1'b0, "rst_drain");
    end
    tick();

    // Illegal opcode: decodes as NOP, sticky flag only when the trap is built in.
    drive(6'h15, 1'b0, 1'b0, "illegal");
    chk("illegal_nop", {bus2.exec_cmd, bus2.wb_en, bus2.is_imm}, 32'd0);
    tick();
    drive(6'h00, 1'b0, 1'b0, "illegal_next");
    chk("illegal_flag", 32'(bus2.illegal_op), 32'(TRAP));
    tick();
    drive(6'h01, 1'b0, 1'b0, "illegal_sticky");
    chk("illegal_sticky", 32'(bus4.illegal_op), 32'(TRAP));
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      op = SEQ;
      else if (r < 85) op = legal_ops[$urandom_range(0, 17)];
      else             op = 6'($urandom);
      st = ($urandom_range(0, 99) < 15);
      fl = ($urandom_range(0, 99) < 7);
      drive(op, st, fl, "rand");
      if ($urandom_range(0, 99) < 2) pulse_reset("rand_rst");
      else                           tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
